// File: rtl/switch_display_pkg.sv
// Seven-segment glyph constants and display-mode type shared by the switch_display block.
// Glyphs are active-low: bit 7 is the decimal point, bits 6..0 are segments g..a.
package seven_seg_pkg;

  typedef enum logic {
    DISP_LEVEL = 1'b0,
    DISP_COUNT = 1'b1
  } disp_mode_e;

  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam int         SEG_DP_BIT = 7;

  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_B = 8'h83;
  localparam logic [7:0] SEG_C = 8'hC6;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_F = 8'h8E;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] i_val);
    logic [7:0] w_seg;
    w_seg = SEG_BLANK;
    case (i_val)
      4'h0: w_seg = SEG_0;
      4'h1: w_seg = SEG_1;
      4'h2: w_seg = SEG_2;
      4'h3: w_seg = SEG_3;
      4'h4: w_seg = SEG_4;
      4'h5: w_seg = SEG_5;
      4'h6: w_seg = SEG_6;
      4'h7: w_seg = SEG_7;
      4'h8: w_seg = SEG_8;
      4'h9: w_seg = SEG_9;
      4'hA: w_seg = SEG_A;
      4'hB: w_seg = SEG_B;
      4'hC: w_seg = SEG_C;
      4'hD: w_seg = SEG_D;
      4'hE: w_seg = SEG_E;
      4'hF: w_seg = SEG_F;
      default: w_seg = SEG_BLANK;
    endcase
    return w_seg;
  endfunction

endpackage

// File: rtl/switch_display_if.sv
// Board-side bundle of switch_display: switch/control inputs and LED/HEX outputs.
// The master drives switches and controls; the slave (the display block) drives the LEDs and digits.
interface switch_display_if #(
  parameter int CHANNELS = 6
);
  logic [CHANNELS-1:0]   SW;
  logic                  MODE;
  logic                  CLR_COUNT;
  logic [CHANNELS-1:0]   LEDR;
  logic [8*CHANNELS-1:0] HEX;

  modport master (
    output SW,
    output MODE,
    output CLR_COUNT,
    input  LEDR,
    input  HEX
  );

  modport slave (
    input  SW,
    input  MODE,
    input  CLR_COUNT,
    output LEDR,
    output HEX
  );
endinterface

// File: rtl/switch_display_debouncer.sv
// One switch channel: two-flop synchroniser, debounce counter and accepted level,
// with combinational rise/change pulses valid in the cycle whose closing edge updates the level.
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sw,
  output logic o_stable,
  output logic o_rise,
  output logic o_change
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  logic             w_accept;

  assign w_diff   = r_sync2 ^ r_stable;
  // The counter only ever reaches CNT_LAST; the increment that would hit DEBOUNCE_CYCLES is the accept.
  assign w_accept = w_diff && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
      if (w_accept) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else if (w_diff) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_stable = r_stable;
  assign o_rise   = w_accept & r_sync2;
  assign o_change = w_accept;

endmodule

// File: rtl/switch_display.sv
// Switch-to-display top: per channel debounce, LED of the stable level, and a 7-segment digit showing
// either the level or a 4-bit rising-edge count. Optional DP flash on change: SWITCH_DISPLAY_DP_FLASH_EN.
module switch_display
  import seven_seg_pkg::*;
#(
  parameter int CHANNELS        = 6,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FLASH_CYCLES    = 12500000
) (
  input  logic            CLOCK_50,
  input  logic            RESET_N,
  switch_display_if.slave bus
);

  if (CHANNELS < 1 || CHANNELS > 6) begin : g_bad_channels
    $error("switch_display: CHANNELS must be 1..6");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("switch_display: DEBOUNCE_CYCLES must be at least 2");
  end
  if (FLASH_CYCLES < 1) begin : g_bad_flash
    $error("switch_display: FLASH_CYCLES must be at least 1");
  end

  logic [CHANNELS-1:0] w_stable;
  logic [CHANNELS-1:0] w_rise;
  logic [CHANNELS-1:0] w_change;
  logic [CHANNELS-1:0] r_led;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_led <= '0;
    end else begin
      r_led <= w_stable;
    end
  end

  assign bus.LEDR = r_led;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [3:0] r_count;
      logic       w_dp;
      logic [7:0] w_glyph;
      logic [7:0] w_hex_next;
      logic [7:0] r_hex;

      switch_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debouncer (
        .i_clk   (CLOCK_50),
        .i_rst_n (RESET_N),
        .i_sw    (bus.SW[gi]),
        .o_stable(w_stable[gi]),
        .o_rise  (w_rise[gi]),
        .o_change(w_change[gi])
      );

      // Clear has priority over a coincident rising edge.
      always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
          r_count <= 4'd0;
        end else if (bus.CLR_COUNT) begin
          r_count <= 4'd0;
        end else if (w_rise[gi]) begin
          r_count <= r_count + 4'd1;
        end
      end

`ifdef SWITCH_DISPLAY_DP_FLASH_EN
      localparam int TMR_W = $clog2(FLASH_CYCLES + 1);
      logic [TMR_W-1:0] r_tmr;

      always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
          r_tmr <= '0;
        end else if (w_change[gi]) begin
          r_tmr <= TMR_W'(FLASH_CYCLES);
        end else if (r_tmr != '0) begin
          r_tmr <= r_tmr - TMR_W'(1);
        end
      end

      assign w_dp = (r_tmr == '0);
`else
      assign w_dp = 1'b1;
`endif

      always_comb begin
        if (disp_mode_e'(bus.MODE) == DISP_COUNT) begin
          w_glyph = hex_to_seg(r_count);
        end else begin
          w_glyph = w_stable[gi] ? SEG_1 : SEG_0;
        end
        w_hex_next             = w_glyph;
        w_hex_next[SEG_DP_BIT] = w_dp;
      end

      always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
          r_hex <= SEG_0;
        end else begin
          r_hex <= w_hex_next;
        end
      end

      assign bus.HEX[8*gi +: 8] = r_hex;
    end
  endgenerate

endmodule

// File: doc/switch_display.md
# switch_display

Parametrised switch-to-display block: each of `CHANNELS` slide switches is synchronised and debounced, the stable level drives an LED, and the channel's 7-segment digit shows either the level (0/1) or a hex count of debounced rising edges. It sits between the board switch pins and the LED/HEX pins at the top of a board design and replaces hard-wired switch-to-LED/HEX decoding.

## Interface
- `CHANNELS`, 6: number of switch/LED/digit channels, legal range 1..6.
- `DEBOUNCE_CYCLES`, 500000: consecutive cycles a new level must persist before it is accepted. Minimum 2. Default is 10 ms at 50 MHz.
- `FLASH_CYCLES`, 12500000: decimal-point flash length. Used only when `SWITCH_DISPLAY_DP_FLASH_EN` is defined.
- `CLOCK_50` input 1: single clock, all logic on the rising edge.
- `RESET_N` input 1: asynchronous, active-low reset.
- `SW` input `CHANNELS`: raw switch levels, asynchronous to the clock.
- `MODE` input 1: display select, synchronous to `CLOCK_50`. 0 shows the level; 1 shows the toggle count.
- `CLR_COUNT` input 1: synchronous clear of all toggle counts, sampled every cycle.
- `LEDR` output `CHANNELS`: debounced switch levels, registered.
- `HEX` output `8*CHANNELS`: active-low segments, registered. Channel i occupies `[8i+7:8i]`. Bit 7 is the decimal point; bits 6..0 are segments g..a.

## Operation
- Per channel, `SW[i]` passes through two flops (`sync1`, `sync2`) before any other use.
- Debounce:
  - While `sync2` differs from `stable`, the counter increments.
  - When `sync2` equals `stable`, the counter clears.
  - When the counter would reach `DEBOUNCE_CYCLES`, `stable` takes `sync2` and the counter clears.
  - Glitches shorter than `DEBOUNCE_CYCLES` are never reflected.
- Edge pulses: one-cycle `rise` on each `stable` 0→1 and one-cycle `change` on any `stable` transition.
- Toggle count: 4 bits per channel.
  - Increments on `rise` and wraps F→0.
  - `CLR_COUNT` clears all counts. When `CLR_COUNT` and `rise` occur together, the clear wins (count = 0).
- Digit encoding:
  - `MODE`=0: `8'hC0` ("0") when `stable`=0, `8'hF9` ("1") when `stable`=1.
  - `MODE`=1: standard hex glyph of the count, 0–F.
  - DP bit is 1 (off) unless the flash feature is active.
- `LEDR[i]` equals `stable[i]`, registered.

## Timing
- Reset values:
  - `sync1`, `sync2`, `stable`, debounce counters, toggle counts all 0.
  - `LEDR` = 0.
  - Every channel's `HEX` slice = `8'hC0`.
  - Flash timers = 0, so DP is off.
- Reset assertion mid-debounce or mid-flash takes effect immediately (asynchronous). Any pending level change is discarded.
- Switch latency: a new level first sampled into `sync1` at edge k, and held, updates `stable` at edge k+1+`DEBOUNCE_CYCLES`. `LEDR`/`HEX` update at edge k+2+`DEBOUNCE_CYCLES`.
- `MODE` and `CLR_COUNT` take effect on `HEX` one edge after they are sampled.
- Channels are fully independent. Simultaneous changes on several channels update on the same edge.

## Configuration
- `SWITCH_DISPLAY_DP_FLASH_EN` defined:
  - Each channel has a timer loaded with `FLASH_CYCLES` on `change`; it decrements to 0.
  - The DP bit is 0 (lit) while the timer is non-zero.
  - A new `change` during a flash reloads the timer.
  - The flash applies in both modes.
- Not defined: no timer logic; the DP bit is constant 1.

## Structure
- Shared package `seven_seg_pkg`:
  - `SEG_BLANK` (`8'hFF`) and `SEG_DP_BIT` (7).
  - Hex-glyph constants `8'hC0, F9, A4, B0, 99, 92, 82, F8, 80, 90, 88, 83, C6, A1, 86, 8E`.
  - Function `hex_to_seg(input [3:0])`.
- Sub-module `switch_debouncer`:
  - One channel: synchroniser, debounce counter, `stable`, `rise`/`change` pulses.
  - Parameter `DEBOUNCE_CYCLES`; instantiated `CHANNELS` times by generate.
- Toggle counts, flash timers and output registers live in the top-level module.

## Test plan
Benches use `DEBOUNCE_CYCLES`=4 and `FLASH_CYCLES`=8.
- Reset: hold `RESET_N`=0 → `LEDR`=0 and every `HEX` slice = `8'hC0`. Assert reset mid-debounce → outputs return to these values without waiting for a clock edge.
- Clean press: `SW[0]` 0→1 sampled at edge k → `LEDR[0]`=1 and `HEX[7:0]`=`8'hF9` at edge k+6, not earlier.
- Glitch: `SW[2]` high for 3 cycles then low → `LEDR[2]` and `HEX[23:16]` never change.
- Count wrap: `MODE`=1, 17 debounced presses on `SW[1]` → `HEX[15:8]` steps through glyphs 1..F, then 0 (`8'hC0`) at press 16, then 1 (`8'hF9`) at press 17.
- Clear collision: assert `CLR_COUNT` on the same cycle as a `rise` with count 5 → count = 0, `HEX` = `8'hC0` on the next edge.
- With `SWITCH_DISPLAY_DP_FLASH_EN`: a debounced change → HEX bit 7 is 0 for exactly 8 cycles. A second change after 5 cycles extends it to 8 cycles from that change. Without the macro, bit 7 stays 1 throughout.
